// File: rtl/mcpu_key_fifo_pkg.sv
// Shared constants for the keyboard event FIFO.
package mcpu_key_fifo_pkg;

  // Bit of the raw keycode that means "a key is held".
  localparam int KEY_VALID_BIT = 7;

  // Width of the key code carried in each queued event.
  localparam int KEY_CODE_W = 7;

  // The output word marks a valid entry in its top bit, so the CPU can test the sign.
  function automatic int valid_bit_pos(input int data_width);
    return data_width - 1;
  endfunction

endpackage

// File: rtl/mcpu_key_fifo_if.sv
// Bus between the CPU side and the keyboard event FIFO.
//
// Handshake: pop is a single-cycle strobe with no ready. It removes the head
// entry at the clock edge only when empty is low; a pop while empty is ignored.
// Entries are produced internally from keycode press events, so there is no
// push handshake; a press arriving while full is dropped and flagged in overflow.
interface mcpu_key_fifo_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH_LOG2 = 3
);
  logic [7:0]            keycode;
  logic                  pop;
  logic                  clear;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  empty;
  logic                  full;
  logic                  overflow;
  logic [DEPTH_LOG2:0]   count;

  modport master (
    output keycode, pop, clear,
    input  data_out, empty, full, overflow, count
  );

  modport slave (
    input  keycode, pop, clear,
    output data_out, empty, full, overflow, count
  );
endinterface

// File: rtl/mcpu_sync_fifo.sv
// Generic count-based synchronous FIFO with a combinational head word.
module mcpu_sync_fifo #(
  parameter int WIDTH      = 7,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  clear,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      head,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  // Full/empty come from the count so pointer equality is never ambiguous.
  assign full  = (count == DEPTH_CNT);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // A pop on a full FIFO frees the slot the coincident push needs; clear wins over both.
  assign do_push = push & (~full | pop) & ~clear;
  assign do_pop  = pop & ~empty & ~clear;

  // Storage write; contents need no reset because empty masks the head.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap modulo depth; count tracks occupancy.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (do_pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (DEPTH_LOG2 + 1)'(1);
        2'b01:   count <= count - (DEPTH_LOG2 + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mcpu_key_fifo.sv
// Keyboard input stage: turns key presses into queued events for the CPU's Y input.
module mcpu_key_fifo
  import mcpu_key_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic            clk,
  input  logic            reset,
  mcpu_key_fifo_if.slave  bus
);
  localparam int VALID_POS = valid_bit_pos(DATA_WIDTH);

  logic [7:0]            key_prev;
  logic                  press;
  logic                  drop;
  logic                  overflow_q;
  logic [KEY_CODE_W-1:0] head;

  // A press is a key going down, or a different code appearing while still held.
  assign press = bus.keycode[KEY_VALID_BIT] &
                 (~key_prev[KEY_VALID_BIT] |
                  (bus.keycode[KEY_CODE_W-1:0] != key_prev[KEY_CODE_W-1:0]));

  // An event is lost only when full and no pop makes room.
  assign drop = press & bus.full & ~bus.pop & ~bus.clear;

  // Previous keycode keeps tracking through clear so a held key is not re-reported.
  always_ff @(posedge clk) begin
    if (reset) key_prev <= 8'h00;
    else       key_prev <= bus.keycode;
  end

  // Sticky overflow flag, cleared only by reset or clear.
  always_ff @(posedge clk) begin
    if (reset || bus.clear) overflow_q <= 1'b0;
    else if (drop)          overflow_q <= 1'b1;
  end

  mcpu_sync_fifo #(
    .WIDTH      (KEY_CODE_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (press),
    .pop   (bus.pop),
    .clear (bus.clear),
    .din   (bus.keycode[KEY_CODE_W-1:0]),
    .head  (head),
    .full  (bus.full),
    .empty (bus.empty),
    .count (bus.count)
  );

  assign bus.overflow = overflow_q;

  // Head formatting: valid flag in the top bit, code in the low bits, zero when empty.
  always_comb begin
    bus.data_out = '0;
    if (!bus.empty) begin
      bus.data_out[KEY_CODE_W-1:0] = head;
      bus.data_out[VALID_POS]      = 1'b1;
    end
  end

endmodule

// File: tb/tb_mcpu_key_fifo.sv
// Self-checking bench for mcpu_key_fifo: vector table, corner sequences, random run.
module tb_mcpu_key_fifo;
  localparam int DW    = 16;
  localparam int DL2   = 3;
  localparam int DEPTH = 8;

  logic clk;
  logic reset;

  mcpu_key_fifo_if #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL2)) bus ();

  mcpu_key_fifo #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [6:0] exp_q[$];
  logic       m_ovf;
  logic [7:0] m_prev;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] m_data();
    if (exp_q.size() == 0) return '0;
    return {1'b1, {(DW-8){1'b0}}, exp_q[0]};
  endfunction

  // One clock of the keyboard queue, expressed as queue operations.
  task automatic model(input logic [7:0] k, input logic p, input logic c, input logic r);
    logic pressed;
    if (r) begin
      exp_q.delete();
      m_ovf  = 1'b0;
      m_prev = 8'h00;
      return;
    end
    pressed = k[7] && (!m_prev[7] || k[6:0] != m_prev[6:0]);
    m_prev  = k;
    if (c) begin
      exp_q.delete();
      m_ovf = 1'b0;
      return;
    end
    if (p && exp_q.size() > 0) void'(exp_q.pop_front());
    if (pressed) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(k[6:0]);
      else                      m_ovf = 1'b1;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".data_out"}, 32'(bus.data_out), 32'(m_data()));
    chk({tag, ".count"},    32'(bus.count),    32'(exp_q.size()));
    chk({tag, ".empty"},    32'(bus.empty),    32'(exp_q.size() == 0));
    chk({tag, ".full"},     32'(bus.full),     32'(exp_q.size() == DEPTH));
    chk({tag, ".overflow"}, 32'(bus.overflow), 32'(m_ovf));
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic [7:0] k, input logic p, input logic c, input logic r,
                      input string tag);
    bus.keycode = k;
    bus.pop     = p;
    bus.clear   = c;
    reset       = r;
    @(posedge clk);
    model(k, p, c, r);
    #1;
    check_model(tag);
  endtask

  task automatic chk_out(input string tag, input int cnt, input logic [DW-1:0] data,
                         input logic ovf);
    chk({tag, ".count"},    32'(bus.count),    32'(cnt));
    chk({tag, ".data_out"}, 32'(bus.data_out), 32'(data));
    chk({tag, ".overflow"}, 32'(bus.overflow), 32'(ovf));
    chk({tag, ".empty"},    32'(bus.empty),    32'(cnt == 0));
    chk({tag, ".full"},     32'(bus.full),     32'(cnt == DEPTH));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0]    keycode;
    logic          pop;
    logic          clear;
    int            exp_count;
    logic [DW-1:0] exp_data;
    logic          exp_ovf;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [7:0] kc;
    logic       rp, rc, rr;

    vecs[0] = '{8'h81, 1'b0, 1'b0, 1, 16'h8001, 1'b0};
    vecs[1] = '{8'h81, 1'b0, 1'b0, 1, 16'h8001, 1'b0};
    vecs[2] = '{8'h82, 1'b0, 1'b0, 2, 16'h8001, 1'b0};
    vecs[3] = '{8'h02, 1'b1, 1'b0, 1, 16'h8002, 1'b0};
    vecs[4] = '{8'h00, 1'b1, 1'b0, 0, 16'h0000, 1'b0};
    vecs[5] = '{8'h00, 1'b1, 1'b0, 0, 16'h0000, 1'b0};
    vecs[6] = '{8'h85, 1'b0, 1'b1, 0, 16'h0000, 1'b0};
    vecs[7] = '{8'h85, 1'b0, 1'b0, 0, 16'h0000, 1'b0};
    vecs[8] = '{8'h86, 1'b1, 1'b0, 1, 16'h8006, 1'b0};
    vecs[9] = '{8'h00, 1'b1, 1'b0, 0, 16'h0000, 1'b0};

    // Reset with no key held.
    exp_q.delete();
    m_ovf  = 1'b0;
    m_prev = 8'h00;
    step(8'h00, 1'b0, 1'b0, 1'b1, "reset0");
    step(8'h00, 1'b0, 1'b0, 1'b1, "reset1");
    chk_out("reset_vals", 0, 16'h0000, 1'b0);

    // Table: press, hold, code change, pops, empty pop, clear with press.
    for (int i = 0; i < 10; i++) begin
      step(vecs[i].keycode, vecs[i].pop, vecs[i].clear, 1'b0, $sformatf("vec%0d", i));
      chk_out($sformatf("vec%0d_exp", i), vecs[i].exp_count, vecs[i].exp_data, vecs[i].exp_ovf);
    end

    // Long hold reports exactly once.
    step(8'h81, 1'b0, 1'b0, 1'b0, "hold_press");
    for (int i = 0; i < 50; i++) step(8'h81, 1'b0, 1'b0, 1'b0, "hold");
    chk_out("hold_end", 1, 16'h8001, 1'b0);
    step(8'h81, 1'b1, 1'b0, 1'b0, "hold_pop");
    step(8'h00, 1'b0, 1'b0, 1'b0, "release");
    chk_out("hold_drained", 0, 16'h0000, 1'b0);

    // Nine presses with no pops: the ninth is dropped.
    for (int i = 1; i <= 9; i++) step(8'h80 | 8'(i), 1'b0, 1'b0, 1'b0, "fill9");
    chk_out("fill9_end", 8, 16'h8001, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      chk(("drain_head"), 32'(bus.data_out), 32'(16'h8000 | 16'(i)));
      step(8'h00, 1'b1, 1'b0, 1'b0, "drain");
    end
    chk_out("drain_end", 0, 16'h0000, 1'b1);
    step(8'h00, 1'b0, 1'b1, 1'b0, "clear_ovf");
    chk_out("clear_ovf_end", 0, 16'h0000, 1'b0);

    // Full with coincident press and pop: no overflow, new entry lands last.
    for (int i = 1; i <= 8; i++) step(8'h80 | 8'(i), 1'b0, 1'b0, 1'b0, "fill8");
    chk_out("fill8_end", 8, 16'h8001, 1'b0);
    step(8'h8A, 1'b1, 1'b0, 1'b0, "full_pushpop");
    chk_out("full_pushpop_end", 8, 16'h8002, 1'b0);
    for (int i = 0; i < 7; i++) step(8'h00, 1'b1, 1'b0, 1'b0, "drain_a");
    chk("last_entry", 32'(bus.data_out), 32'(16'h800A));
    step(8'h00, 1'b1, 1'b0, 1'b0, "drain_last");
    chk_out("drain_a_end", 0, 16'h0000, 1'b0);

    // Empty pop with coincident press: push wins.
    step(8'h84, 1'b1, 1'b0, 1'b0, "empty_pushpop");
    chk_out("empty_pushpop_end", 1, 16'h8004, 1'b0);
    step(8'h00, 1'b1, 1'b0, 1'b0, "empty_pushpop_drain");

    // Pointer wrap: 20 push/pop pairs.
    for (int i = 0; i < 20; i++) begin
      step(8'h80 | 8'(10 + i), 1'b0, 1'b0, 1'b0, "wrap_push");
      chk("wrap_head", 32'(bus.data_out), 32'(16'h8000 | 16'(10 + i)));
      step(8'h00, 1'b1, 1'b0, 1'b0, "wrap_pop");
    end
    chk_out("wrap_end", 0, 16'h0000, 1'b0);

    // Reset while a key is held and three entries are queued.
    step(8'h81, 1'b0, 1'b0, 1'b0, "pre_rst1");
    step(8'h82, 1'b0, 1'b0, 1'b0, "pre_rst2");
    step(8'h83, 1'b0, 1'b0, 1'b0, "pre_rst3");
    chk_out("pre_rst_end", 3, 16'h8001, 1'b0);
    step(8'h83, 1'b0, 1'b0, 1'b1, "held_reset");
    chk_out("held_reset_vals", 0, 16'h0000, 1'b0);
    step(8'h83, 1'b0, 1'b0, 1'b0, "after_reset");
    chk_out("after_reset_vals", 1, 16'h8003, 1'b0);

    // Random run against the queue model.
    kc = 8'h00;
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0:       kc = 8'h00;
        1:       kc = kc;
        default: kc = 8'h80 | 8'($urandom_range(1, 5));
      endcase
      rp = ($urandom_range(0, 99) < 30);
      rc = ($urandom_range(0, 99) < 3);
      rr = ($urandom_range(0, 99) < 1);
      step(kc, rp, rc, rr, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mcpu_key_fifo.md
Name: mcpu_key_fifo

Overview:
- Keyboard input stage directly upstream of the mcpu_core Y ALU input, replacing the raw level-sampled keycode.
- Detects key-press events on the 8-bit top-level keycode input and queues them in a small FIFO.
- The CPU pops one event per read strobe, so presses shorter than a CPU polling loop are never lost.
- Output word is DATA_WIDTH wide and drives alu_y directly.

Parameters:
- DATA_WIDTH, 16, width of data_out; must be >= 9.
- DEPTH_LOG2, 3, log2 of FIFO depth (default 8 entries).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- keycode  input  8  top-level keycode; bit7 = key held, bits[6:0] = key code
- pop  input  1  single-cycle strobe; removes the head entry
- clear  input  1  flushes the FIFO and clears overflow
- data_out  output  DATA_WIDTH  head word: {1'b1, zeros, code[6:0]} when non-empty, all-zero when empty
- empty  output  1  FIFO holds 0 entries
- full  output  1  FIFO holds 2^DEPTH_LOG2 entries
- overflow  output  1  sticky; set when a press event is dropped
- count  output  DEPTH_LOG2+1  number of entries held

Behaviour:
- One clock; reset is synchronous and active-high. The clock port is clk and the reset port is reset.
- Reset values:
  - Pointers and count = 0; empty = 1; full = 0; overflow = 0; data_out = 0.
  - key_prev register = 8'h00.
  - A key held through reset is therefore reported once, on the first cycle after reset.
- Edge detect:
  - key_prev <= keycode every cycle.
  - press = keycode[7] & (~key_prev[7] | (keycode[6:0] != key_prev[6:0])).
  - A code change while bit7 stays high counts as a new press.
  - Releases are never queued.
- Push:
  - When press is high in cycle k, keycode[6:0] is written at edge k.
  - empty deasserts and count increments after edge k (one-edge latency).
- Pop:
  - When pop is high and FIFO is non-empty, the head advances at the edge.
  - data_out shows the next entry (or 0) immediately after that edge.
  - data_out is combinational from registered storage and head pointer; no extra read latency.
  - A pop while empty is ignored; count stays 0 and no pointer moves.
- Simultaneous push and pop:
  - Both occur; count is unchanged.
  - When full, the pop frees the slot, the push succeeds, and overflow is not set.
  - When empty, the push wins; the pop is ignored that cycle.
- Push while full without pop: event dropped, overflow <= 1 (sticky until clear or reset).
- Clear:
  - Highest priority after reset. Pointers and count go to 0, overflow goes to 0.
  - A coincident push or pop is discarded.
  - key_prev still updates, so a held key is not re-reported.
- Pointers are DEPTH_LOG2 bits wide and wrap modulo depth; full/empty derive from count, not from pointer equality.
- data_out bits [DATA_WIDTH-2:7] are always 0, so the CPU can test bit DATA_WIDTH-1 (sign) for valid.

Decomposition:
- Shared package contents:
  - KEY_VALID_BIT = 7
  - KEY_CODE_W = 7
  - data_out valid-bit position function of DATA_WIDTH
- One sub-module, mcpu_sync_fifo: generic count-based synchronous FIFO with push, pop, clear, full, empty, count and a combinational head.
- The top module holds the edge detector, overflow logic and output formatting.

Test Plan:
- Reset with keycode=8'h00, then keycode=8'h81 for 1 cycle -> after the edge count=1, data_out=16'h8001; keycode held at 8'h81 for 50 cycles -> count stays 1.
- keycode 8'h81 -> 8'h82 with no release between -> two entries; pop -> data_out=16'h8002; pop -> data_out=16'h0000, empty=1.
- 9 distinct presses (codes 1..9) with no pops -> full=1, count=8, overflow=1, head=16'h8001; 8 pops yield codes 1..8 in order.
- With FIFO full, press code 8'h8A and pop in the same cycle -> count stays 8, overflow stays 0, the last entry popped is 16'h800A.
- Pop while empty, and clear coincident with a press of 8'h85 -> count=0, empty=1, overflow=0, no entry queued; a pointer-wrap run of 20 push/pop pairs returns every code in order.
- Reset asserted while keycode=8'h83 is held and count=3 -> all outputs return to their reset values; one cycle after reset deasserts, count=1 and data_out=16'h8003.
